// File: rtl/bouncing_square.sv
// Filled square bouncing diagonally inside the active video area, frame-locked motion.
// Optional macro BOUNCE_COLOUR_EN: advance the square colour on every bounce step.
module bouncing_square #(
    parameter int unsigned H_VIDEO         = 640,
    parameter int unsigned V_VIDEO         = 480,
    parameter int unsigned SQUARE_W        = 16,
    parameter int unsigned STEP_X          = 2,
    parameter int unsigned STEP_Y          = 1,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned X_INIT          = 0,
    parameter int unsigned Y_INIT          = 0
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       pause,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [7:0] bounce_cnt
);

    localparam int unsigned X_MAX = H_VIDEO - SQUARE_W;
    localparam int unsigned Y_MAX = V_VIDEO - SQUARE_W;
    localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
    localparam logic signed [10:0] STEP_X_S = 11'(STEP_X);
    localparam logic signed [10:0] STEP_Y_S = 11'(STEP_Y);
    localparam logic [7:0]  DIV_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [10:0] SIDE     = 11'(SQUARE_W);

    logic [9:0] x_pos, y_pos, x_nxt, y_nxt;
    logic       dir_x_neg, dir_y_neg, dir_x_nxt, dir_y_nxt;
    logic [2:0] colour, colour_nxt;
    logic [7:0] frame_div, frame_div_nxt;
    logic [7:0] bounce_nxt;
    logic [2:0] rgb_nxt;
    logic       match_q;

    logic              match_c, tick_c, step_c, hit_x_c, hit_y_c, in_sq_c;
    logic signed [10:0] x_sum_c, y_sum_c;

    // Tick on the first cycle of the first blanking line; edge-qualified so it fires once.
    assign match_c = (pixel_x == 10'd0) && (pixel_y == 10'(V_VIDEO));
    assign tick_c  = match_c && !match_q;

    assign in_sq_c = (pixel_x >= x_pos) && (11'(pixel_x) < 11'(x_pos) + SIDE) &&
                     (pixel_y >= y_pos) && (11'(pixel_y) < 11'(y_pos) + SIDE);

    assign x_sum_c = dir_x_neg ? ($signed({1'b0, x_pos}) - STEP_X_S)
                               : ($signed({1'b0, x_pos}) + STEP_X_S);
    assign y_sum_c = dir_y_neg ? ($signed({1'b0, y_pos}) - STEP_Y_S)
                               : ($signed({1'b0, y_pos}) + STEP_Y_S);

    // Next-state: frame divider, per-axis reflection, bounce accounting and pixel colour.
    always_comb begin
        x_nxt         = x_pos;
        y_nxt         = y_pos;
        dir_x_nxt     = dir_x_neg;
        dir_y_nxt     = dir_y_neg;
        frame_div_nxt = frame_div;
        bounce_nxt    = bounce_cnt;
        colour_nxt    = colour;
        step_c        = 1'b0;
        hit_x_c       = 1'b0;
        hit_y_c       = 1'b0;
        rgb_nxt       = (video_on && in_sq_c) ? colour : 3'b000;

        if (tick_c && !pause) begin
            if (frame_div == DIV_LAST) begin
                step_c        = 1'b1;
                frame_div_nxt = 8'd0;
            end else begin
                frame_div_nxt = frame_div + 8'd1;
            end
        end

        if (step_c) begin
            if (x_sum_c > X_MAX_S) begin
                x_nxt     = 10'(X_MAX);
                dir_x_nxt = 1'b1;
                hit_x_c   = 1'b1;
            end else if (x_sum_c < 11'sd0) begin
                x_nxt     = 10'd0;
                dir_x_nxt = 1'b0;
                hit_x_c   = 1'b1;
            end else begin
                x_nxt = 10'(x_sum_c);
            end

            if (y_sum_c > Y_MAX_S) begin
                y_nxt     = 10'(Y_MAX);
                dir_y_nxt = 1'b1;
                hit_y_c   = 1'b1;
            end else if (y_sum_c < 11'sd0) begin
                y_nxt     = 10'd0;
                dir_y_nxt = 1'b0;
                hit_y_c   = 1'b1;
            end else begin
                y_nxt = 10'(y_sum_c);
            end

            // A corner counts as a single bounce.
            if (hit_x_c || hit_y_c) begin
                bounce_nxt = bounce_cnt + 8'd1;
`ifdef BOUNCE_COLOUR_EN
                colour_nxt = (colour == 3'b111) ? 3'b001 : colour + 3'd1;
`endif
            end
        end

`ifndef BOUNCE_COLOUR_EN
        colour_nxt = 3'b111;
`endif
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            x_pos      <= 10'(X_INIT);
            y_pos      <= 10'(Y_INIT);
            dir_x_neg  <= 1'b0;
            dir_y_neg  <= 1'b0;
            colour     <= 3'b111;
            frame_div  <= 8'd0;
            bounce_cnt <= 8'd0;
            match_q    <= 1'b0;
            red        <= 1'b0;
            green      <= 1'b0;
            blue       <= 1'b0;
        end else begin
            x_pos      <= x_nxt;
            y_pos      <= y_nxt;
            dir_x_neg  <= dir_x_nxt;
            dir_y_neg  <= dir_y_nxt;
            colour     <= colour_nxt;
            frame_div  <= frame_div_nxt;
            bounce_cnt <= bounce_nxt;
            match_q    <= match_c;
            {red, green, blue} <= rgb_nxt;
        end
    end

endmodule
